// File: rtl/ocu_weight_loader_if.sv
// Weight-memory and threshold handshake bundle feeding the OCU weight loader.
// The master is the data source; the slave is the loader.
interface ocu_weight_loader_if #(
    parameter int WORD_W   = 128,
    parameter int TH_WIDTH = 14
);
    logic                       mem_valid;
    logic                       mem_ready;
    logic [WORD_W-1:0]          mem_data;
    logic                       thresh_valid;
    logic                       thresh_ready;
    logic signed [TH_WIDTH-1:0] thresh_pos;
    logic signed [TH_WIDTH-1:0] thresh_neg;

    modport master (
        output mem_valid, mem_data, thresh_valid, thresh_pos, thresh_neg,
        input  mem_ready, thresh_ready
    );

    modport slave (
        input  mem_valid, mem_data, thresh_valid, thresh_pos, thresh_neg,
        output mem_ready, thresh_ready
    );
endinterface

// File: rtl/ocu_weight_loader.sv
// Sequencer that loads one kernel set plus its threshold pair into the OCU shadow
// weight bank while the active bank computes, and swaps banks on request.
module ocu_weight_loader #(
    parameter int N_I            = 512,
    parameter int K              = 3,
    parameter int WEIGHT_STAGGER = 8,
    parameter int TH_WIDTH       = $clog2(K*K*N_I) + 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         start_i,
    input  logic                                         swap_i,
    input  logic                                         abort_i,
    ocu_weight_loader_if.slave                           bus_if,
    output logic [(N_I/WEIGHT_STAGGER)*2-1:0]            weights_o,
    output logic [WEIGHT_STAGGER-1:0][K-1:0][K-1:0]      weights_save_enable_o,
    output logic [WEIGHT_STAGGER-1:0]                    weights_flush_o,
    output logic                                         weights_save_bank_o,
    output logic                                         weights_read_bank_o,
    output logic signed [TH_WIDTH-1:0]                   thresh_pos_o,
    output logic signed [TH_WIDTH-1:0]                   thresh_neg_o,
    output logic                                         threshold_store_o,
    output logic                                         busy_o,
    output logic                                         loaded_o,
    output logic                                         done_o
);
    localparam int WORD_W = (N_I / WEIGHT_STAGGER) * 2;
    localparam int BW     = (WEIGHT_STAGGER > 1) ? $clog2(WEIGHT_STAGGER) : 1;
    localparam int KW     = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_LOAD, S_THRESH, S_READY} state_t;

    state_t                                    state_q, state_d;
    logic [BW-1:0]                             blk_q, blk_d;
    logic [KW-1:0]                             col_q, col_d;
    logic [KW-1:0]                             line_q, line_d;
    logic [WORD_W-1:0]                         weights_q;
    logic [WEIGHT_STAGGER-1:0][K-1:0][K-1:0]   save_en_q, save_en_d;
    logic signed [TH_WIDTH-1:0]                tpos_q, tneg_q;
    logic                                      store_q, store_d;
    logic                                      done_q, done_d;
    logic                                      read_bank_q, read_bank_d;
    logic                                      mem_hs, th_hs, swap_go, last_word;

    // abort_i overrides every other input, so it also kills any coincident handshake
    assign mem_hs    = (state_q == S_LOAD)   && bus_if.mem_valid    && !abort_i;
    assign th_hs     = (state_q == S_THRESH) && bus_if.thresh_valid && !abort_i;
    assign swap_go   = (state_q == S_READY)  && swap_i              && !abort_i;
    assign last_word = (blk_q == BW'(WEIGHT_STAGGER-1)) && (col_q == KW'(K-1))
                    && (line_q == KW'(K-1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start_i) state_d = S_FLUSH;
                S_FLUSH:  state_d = S_LOAD;
                S_LOAD:   if (mem_hs && last_word) state_d = S_THRESH;
                S_THRESH: if (th_hs) state_d = S_READY;
                S_READY:  if (swap_go) state_d = start_i ? S_FLUSH : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_if.mem_ready    = (state_q == S_LOAD);
        bus_if.thresh_ready = (state_q == S_THRESH);
        weights_flush_o     = {WEIGHT_STAGGER{state_q == S_FLUSH}};
        busy_o              = (state_q != S_IDLE);
        loaded_o            = (state_q == S_READY);
        save_en_d           = '0;
        if (mem_hs) begin
            save_en_d[blk_q][line_q][col_q] = 1'b1;
        end
        store_d     = th_hs;
        done_d      = swap_go;
        read_bank_d = read_bank_q ^ swap_go;
    end

    // Word index runs block fastest, then column, then line
    always_comb begin
        blk_d  = blk_q;
        col_d  = col_q;
        line_d = line_q;
        if (abort_i || (state_q == S_FLUSH)) begin
            blk_d  = '0;
            col_d  = '0;
            line_d = '0;
        end else if (mem_hs) begin
            if (blk_q == BW'(WEIGHT_STAGGER-1)) begin
                blk_d = '0;
                if (col_q == KW'(K-1)) begin
                    col_d  = '0;
                    line_d = (line_q == KW'(K-1)) ? '0 : line_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_q       <= '0;
            col_q       <= '0;
            line_q      <= '0;
            weights_q   <= '0;
            save_en_q   <= '0;
            tpos_q      <= '0;
            tneg_q      <= '0;
            store_q     <= 1'b0;
            done_q      <= 1'b0;
            read_bank_q <= 1'b0;
        end else begin
            blk_q       <= blk_d;
            col_q       <= col_d;
            line_q      <= line_d;
            save_en_q   <= save_en_d;
            store_q     <= store_d;
            done_q      <= done_d;
            read_bank_q <= read_bank_d;
            if (mem_hs) begin
                weights_q <= bus_if.mem_data;
            end
            if (th_hs) begin
                tpos_q <= bus_if.thresh_pos;
                tneg_q <= bus_if.thresh_neg;
            end
        end
    end

    assign weights_o             = weights_q;
    assign weights_save_enable_o = save_en_q;
    assign weights_read_bank_o   = read_bank_q;
    assign weights_save_bank_o   = ~read_bank_q;
    assign thresh_pos_o          = tpos_q;
    assign thresh_neg_o          = tneg_q;
    assign threshold_store_o     = store_q;
    assign done_o                = done_q;
endmodule
